// File: rtl/snake_pkg.sv
// Shared constants, decoder state and key-map helpers for the snake keyboard input path.
package snake_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_e;

  function automatic logic [2:0] opposite_dir(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      default:   opposite_dir = DIR_NONE;
    endcase
  endfunction

  // DIR_NONE means the code is not a movement key for that player.
  function automatic logic [2:0] p1_key_dir(input logic [7:0] code);
    case (code)
      SC_W:    p1_key_dir = DIR_UP;
      SC_D:    p1_key_dir = DIR_RIGHT;
      SC_S:    p1_key_dir = DIR_DOWN;
      SC_A:    p1_key_dir = DIR_LEFT;
      default: p1_key_dir = DIR_NONE;
    endcase
  endfunction

  function automatic logic [2:0] p2_key_dir(input logic [7:0] code);
    case (code)
      SC_UP:    p2_key_dir = DIR_UP;
      SC_RIGHT: p2_key_dir = DIR_RIGHT;
      SC_DOWN:  p2_key_dir = DIR_DOWN;
      SC_LEFT:  p2_key_dir = DIR_LEFT;
      default:  p2_key_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronisers, falling-edge sampling, 11-bit frame
// check and an idle timeout that abandons partial frames.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          byte_valid_q, frame_err_q;
  logic [7:0]    byte_q, byte_d;

  logic        fall, done, ok, timeout;
  logic [10:0] frame;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  // frame[0] start, [8:1] data LSB first, [9] parity, [10] stop
  assign frame   = {dat_sync_q[1], shift_q};
  assign done    = fall && (bit_cnt_q == 4'd10);
  assign ok      = ~frame[0] & frame[10] & (^frame[9:1]);
  assign timeout = !fall && (idle_q == IW'(TIMEOUT_CYCLES)) && (bit_cnt_q != 4'd0);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    idle_d    = (idle_q == IW'(TIMEOUT_CYCLES)) ? idle_q : idle_q + IW'(1);
    if (fall) begin
      idle_d = '0;
      if (done) begin
        bit_cnt_d = 4'd0;
        if (ok) byte_d = frame[8:1];
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_sync_q[1], shift_q[9:1]};
      end
    end else if (timeout) begin
      bit_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q   <= '0;
      dat_sync_q   <= '0;
      clk_prev_q   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_q       <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q   <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q   <= clk_sync_q[1];
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      byte_valid_q <= done & ok;
      frame_err_q  <= (done & ~ok) | timeout;
      byte_q       <= byte_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/snake_move_input.sv
// Scan-code decoder and per-frame direction commit for two snake players.
// Optional REVERSE_GUARD_EN rejects presses opposite to the committed direction.
module snake_move_input
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int P1_RESET_DIR   = 2,
  parameter int P2_RESET_DIR   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        isDrawing,
  output logic [31:0] move1,
  output logic [31:0] move2,
  output logic [7:0]  lastCode,
  output logic        frameError
);

  logic       byte_valid;
  logic [7:0] rx_byte;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk_i        (clock),
    .rst_i        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_valid_o (byte_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (frameError)
  );

  dec_state_e state_q, state_d;
  logic [2:0] pend1_q, pend1_d, pend2_q, pend2_d;
  logic [2:0] move1_q, move1_d, move2_q, move2_d;
  logic [2:0] key1, key2;
  logic       draw_q, commit;

  assign commit = draw_q & ~isDrawing;

  always_comb begin
    state_d = state_q;
    key1    = DIR_NONE;
    key2    = DIR_NONE;
    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == SC_EXT)      state_d = ST_EXT;
          else if (rx_byte == SC_BRK) state_d = ST_BRK;
          else                        key1 = p1_key_dir(rx_byte);
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key2    = p2_key_dir(rx_byte);
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;  // releases are swallowed
      endcase
    end
  end

  always_comb begin
    pend1_d = pend1_q;
    pend2_d = pend2_q;
`ifdef REVERSE_GUARD_EN
    // Guard against the committed move so two presses in one frame cannot reverse.
    if (key1 != DIR_NONE && key1 != opposite_dir(move1_q)) pend1_d = key1;
    if (key2 != DIR_NONE && key2 != opposite_dir(move2_q)) pend2_d = key2;
`else
    if (key1 != DIR_NONE) pend1_d = key1;
    if (key2 != DIR_NONE) pend2_d = key2;
`endif
    move1_d = commit ? pend1_q : move1_q;
    move2_d = commit ? pend2_q : move2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend1_q <= 3'(P1_RESET_DIR);
      pend2_q <= 3'(P2_RESET_DIR);
      move1_q <= 3'(P1_RESET_DIR);
      move2_q <= 3'(P2_RESET_DIR);
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      move1_q <= move1_d;
      move2_q <= move2_d;
      draw_q  <= isDrawing;
    end
  end

  assign move1    = {29'd0, move1_q};
  assign move2    = {29'd0, move2_q};
  assign lastCode = rx_byte;

endmodule

// File: tb/tb_snake_move_input.sv
// Randomised self-checking bench for snake_move_input against a key-event model.
module tb_snake_move_input;

  localparam int TO   = 300;
  localparam int HALF = 8;

  logic gclk = 1'b0;
  logic rst, ps2_clk, ps2_data, isDrawing;
  logic [31:0] move1, move2;
  logic [7:0]  lastCode;
  logic        frameError;

  snake_move_input #(.TIMEOUT_CYCLES(TO), .P1_RESET_DIR(2), .P2_RESET_DIR(4)) dut (
    .clock(gclk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .isDrawing(isDrawing), .move1(move1), .move2(move2),
    .lastCode(lastCode), .frameError(frameError)
  );

  always #5 gclk = ~gclk;

  int checks = 0, errors = 0;
  int err_seen = 0, err_exp = 0;
  always @(posedge gclk) if (frameError === 1'b1) err_seen++;

  // Model: pending/committed per player plus "after E0" / "after F0" flags.
  int m_pend1, m_pend2, m_move1, m_move2, m_last;
  bit m_ext, m_brk;

  function automatic int p1_map(input int b);
    case (b)
      'h1D: return 1; 'h23: return 2; 'h1B: return 3; 'h1C: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int p2_map(input int b);
    case (b)
      'h75: return 1; 'h74: return 2; 'h72: return 3; 'h6B: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit rejected(input int d, input int committed);
`ifdef REVERSE_GUARD_EN
    return d == ((committed + 1) % 4) + 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pend1 = 2; m_pend2 = 4; m_move1 = 2; m_move2 = 4; m_last = 0;
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input int b);
    int d;
    m_last = b;
    if (m_brk) begin
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 'hF0) m_brk = 1;
      else begin
        d = p2_map(b);
        if (d != 0 && !rejected(d, m_move2)) m_pend2 = d;
        m_ext = 0;
      end
    end else if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else begin
      d = p1_map(b);
      if (d != 0 && !rejected(d, m_move1)) m_pend1 = d;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge gclk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge gclk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge gclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b0, 11);
    model_byte(int'(b));
  endtask

  task automatic frame_edge();
    isDrawing = 1'b1;
    repeat (2) @(negedge gclk);
    isDrawing = 1'b0;
    @(posedge gclk); #1;
    m_move1 = m_pend1; m_move2 = m_pend2;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; isDrawing = 1'b0;
    repeat (3) @(negedge gclk);
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (move1 !== 32'd2 || move2 !== 32'd4) begin errors++;
      $display("FAIL reset_moves got %0d/%0d want 2/4", move1, move2); end
    checks++; if (lastCode !== 8'h00 || frameError !== 1'b0) begin errors++;
      $display("FAIL reset_code got %h/%b want 00/0", lastCode, frameError); end
    rst = 1'b0;
    repeat (3) frame_edge();
    checks++; if (move1 !== 32'd2 || move2 !== 32'd4 || err_seen != 0) begin errors++;
      $display("FAIL idle_frames got %0d/%0d err %0d want 2/4 err 0", move1, move2, err_seen); end
  endtask

  task automatic test_press();
    send_byte(8'h1D);
    isDrawing = 1'b1;
    repeat (2) @(negedge gclk);
    isDrawing = 1'b0;
    checks++; if (move1 !== 32'd2) begin errors++;
      $display("FAIL press_before_edge got %0d want 2", move1); end
    @(posedge gclk); #1;
    m_move1 = m_pend1; m_move2 = m_pend2;
    checks++; if (move1 !== 32'd1 || move2 !== 32'd4) begin errors++;
      $display("FAIL press_commit got %0d/%0d want 1/4", move1, move2); end
    checks++; if (lastCode !== 8'h1D) begin errors++;
      $display("FAIL press_lastcode got %h want 1d", lastCode); end
  endtask

  task automatic test_release();
    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    frame_edge();
    checks++; if (move2 !== 32'd3 || move2 !== 32'(m_move2)) begin errors++;
      $display("FAIL release_move2 got %0d want 3", move2); end
    send_byte(8'h1C);  // only decodes as a press if the FSM returned to IDLE
    checks++; if (int'(dut.pend1_q) != m_pend1 || m_pend1 != 4) begin errors++;
      $display("FAIL release_idle pend1 got %0d want %0d", dut.pend1_q, m_pend1); end
  endtask

  task automatic test_parity_err();
    logic [7:0] code0;
    code0 = lastCode;
    send_raw(8'h23, 1'b1, 11);
    err_exp++;
    checks++; if (err_seen != err_exp) begin errors++;
      $display("FAIL parity_pulse got %0d want %0d", err_seen, err_exp); end
    checks++; if (lastCode !== code0) begin errors++;
      $display("FAIL parity_lastcode got %h want %h", lastCode, code0); end
    frame_edge();
    checks++; if (move1 !== 32'(m_move1) || move1 == 32'd2) begin errors++;
      $display("FAIL parity_move1 got %0d want %0d", move1, m_move1); end
  endtask

  task automatic test_timeout();
    send_byte(8'h1D);
    send_raw(8'h1C, 1'b0, 5);
    repeat (TO + 20) @(negedge gclk);
    err_exp++;
    checks++; if (err_seen != err_exp) begin errors++;
      $display("FAIL timeout_pulse got %0d want %0d", err_seen, err_exp); end
    send_byte(8'h1C);
    checks++; if (int'(dut.pend1_q) != m_pend1 || m_pend1 != 4 || lastCode !== 8'h1C) begin errors++;
      $display("FAIL timeout_recover pend1 %0d code %h want 4 1c", dut.pend1_q, lastCode); end
    checks++; if (err_seen != err_exp) begin errors++;
      $display("FAIL timeout_extra_err got %0d want %0d", err_seen, err_exp); end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hE0);
    send_raw(8'h74, 1'b0, 4);
    do_reset();
    rst = 1'b0;
    @(negedge gclk);
    send_byte(8'h74);  // FSM back in IDLE, so no player-2 press
    checks++; if (int'(dut.pend2_q) != 4 || lastCode !== 8'h74) begin errors++;
      $display("FAIL midreset pend2 %0d code %h want 4 74", dut.pend2_q, lastCode); end
  endtask

  task automatic test_guard();
    int want;
    do_reset();
    rst = 1'b0;
    @(negedge gclk);
    send_byte(8'h1C);
    frame_edge();
`ifdef REVERSE_GUARD_EN
    want = 2;
`else
    want = 4;
`endif
    checks++; if (move1 !== 32'(want) || want != m_move1) begin errors++;
      $display("FAIL guard_single got %0d want %0d", move1, want); end
    send_byte(8'h1D); send_byte(8'h1C);
    frame_edge();
`ifdef REVERSE_GUARD_EN
    want = 1;
`else
    want = 4;
`endif
    checks++; if (move1 !== 32'(want) || want != m_move1) begin errors++;
      $display("FAIL guard_double got %0d want %0d", move1, want); end
  endtask

  task automatic test_random();
    logic [7:0] pool [10];
    logic [7:0] b;
    int r;
    pool = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75, 8'h74, 8'h72, 8'h6B, 8'hE0, 8'hF0};
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 11);
      if (r < 3) frame_edge();
      else if (r == 3) begin
        send_raw(8'($urandom_range(0, 255)), 1'b1, 11);
        err_exp++;
      end else begin
        b = (r == 11) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)];
        send_byte(b);
      end
      checks++; if (move1 !== 32'(m_move1) || move2 !== 32'(m_move2)) begin errors++;
        $display("FAIL rand_moves it %0d got %0d/%0d want %0d/%0d", it, move1, move2, m_move1, m_move2); end
      checks++; if (int'(dut.pend1_q) != m_pend1 || int'(dut.pend2_q) != m_pend2) begin errors++;
        $display("FAIL rand_pend it %0d got %0d/%0d want %0d/%0d", it, dut.pend1_q, dut.pend2_q, m_pend1, m_pend2); end
      checks++; if (int'(lastCode) != m_last || err_seen != err_exp) begin errors++;
        $display("FAIL rand_code it %0d got %h err %0d want %h err %0d", it, lastCode, err_seen, m_last[7:0], err_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_parity_err();
    test_timeout();
    test_reset_midframe();
    test_guard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
